// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the register file and its address decoder.
package cpu_pkg;
  localparam int REG_DATA_W   = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int ZERO_REG_IDX = 0;

  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/onehot_decoder.sv
// Enable-gated binary-to-one-hot decoder; output is all-zero when en is low.
module onehot_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);
  localparam int DEPTH = 2**ADDR_W;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
  end
endmodule

// File: rtl/regfile_onehot.sv
// 1W/2R register file with one-hot write steering, optional hardwired zero entry and write strobe.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_onehot
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_W-1:0]    raddr1,
  input  logic [ADDR_W-1:0]    raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2,
  output logic [2**ADDR_W-1:0] wr_onehot
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG_IDX);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  wr_onehot_q, wr_onehot_d;
  logic [DEPTH-1:0]  wr_dec;
  logic              zero_wr, wen;

  // Writes to the hardwired zero entry are swallowed before decode, so they raise no strobe.
  assign zero_wr = (ZERO_REG != 0) && (waddr == ZIDX);
  assign wen     = we && !rst && !zero_wr;

  onehot_decoder #(.ADDR_W(ADDR_W)) u_wdec (
    .en     (wen),
    .addr   (waddr),
    .onehot (wr_dec)
  );

  always_comb begin
    mem_d       = mem_q;
    wr_onehot_d = wr_dec;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_dec[i]) mem_d[i] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_onehot_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_onehot_q <= wr_onehot_d;
    end
  end

  assign wr_onehot = wr_onehot_q;

  always_comb begin
    rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (wen && (raddr1 == waddr)) rdata1 = wdata;
`endif
    if ((ZERO_REG != 0) && (raddr1 == ZIDX)) rdata1 = '0;
  end

  always_comb begin
    rdata2 = mem_q[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (wen && (raddr2 == waddr)) rdata2 = wdata;
`endif
    if ((ZERO_REG != 0) && (raddr2 == ZIDX)) rdata2 = '0;
  end
endmodule

// File: tb/tb_regfile_onehot.sv
// Random + directed bench for regfile_onehot: ZERO_REG=1 and ZERO_REG=0 instances vs array model.
module tb_regfile_onehot;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, we;
  reg_addr_t   waddr, raddr1, raddr2;
  reg_data_t   wdata;
  reg_data_t   rd1_z, rd2_z, rd1_n, rd2_n;
  logic [31:0] oh_z, oh_n;

  int checks = 0;
  int errors = 0;

  // Reference state: plain arrays of register contents and expected strobes.
  reg_data_t   m_z [32];
  reg_data_t   m_n [32];
  logic [31:0] e_oh_z, e_oh_n;

  always #5 clk = ~clk;

  regfile_onehot #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_z), .rdata2(rd2_z), .wr_onehot(oh_z)
  );

  regfile_onehot #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n), .wr_onehot(oh_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic reg_data_t exp_rd(input bit zr, input reg_addr_t a);
    if (zr && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && a == waddr && !(zr && waddr == 0)) return wdata;
`endif
    return zr ? m_z[a] : m_n[a];
  endfunction

  task automatic drive(input logic r, input logic w, input reg_addr_t wa, input reg_data_t wd,
                       input reg_addr_t a1, input reg_addr_t a2);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    #2;
  endtask

  task automatic pre_chk(input string tag);
    chk({tag, ".rd1z"}, rd1_z, exp_rd(1'b1, raddr1));
    chk({tag, ".rd2z"}, rd2_z, exp_rd(1'b1, raddr2));
    chk({tag, ".rd1n"}, rd1_n, exp_rd(1'b0, raddr1));
    chk({tag, ".rd2n"}, rd2_n, exp_rd(1'b0, raddr2));
  endtask

  task automatic edge_chk(input string tag);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_z[i] = '0; m_n[i] = '0; end
      e_oh_z = '0; e_oh_n = '0;
    end else if (we) begin
      m_n[waddr] = wdata;
      e_oh_n     = 32'd1 << waddr;
      if (waddr == 0) e_oh_z = '0;
      else begin m_z[waddr] = wdata; e_oh_z = 32'd1 << waddr; end
    end else begin
      e_oh_z = '0; e_oh_n = '0;
    end
    #1;
    chk({tag, ".ohz"}, oh_z, e_oh_z);
    chk({tag, ".ohn"}, oh_n, e_oh_n);
  endtask

  task automatic cyc(input string tag, input logic r, input logic w, input reg_addr_t wa,
                     input reg_data_t wd, input reg_addr_t a1, input reg_addr_t a2);
    drive(r, w, wa, wd, a1, a2);
    pre_chk(tag);
    edge_chk(tag);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    for (int i = 0; i < 32; i++) begin m_z[i] = '0; m_n[i] = '0; end
    e_oh_z = '0; e_oh_n = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.oh", oh_z, 32'h0);

    // Reset contents read as zero on both instances.
    for (int a = 0; a < 32; a += 7) cyc("rst.rd", 1'b0, 1'b0, 5'd0, '0, 5'(a), 5'(a + 1));

    // we=0 leaves entry 7 untouched and raises no strobe.
    cyc("we0", 1'b0, 1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
    chk("we0.oh", oh_z, 32'h0);
    cyc("we0.rb", 1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd7);
    chk("we0.e7", rd1_z, 32'h0);

    // Decoder sweep.
    for (int a = 0; a < 32; a++) begin
      cyc("sweep", 1'b0, 1'b1, 5'(a), 32'hA5000000 | a, 5'(a), 5'(a - 1));
      if (a == 0) chk("sweep.oh0", oh_z, 32'h0);
      if (a == 4) chk("sweep.oh4", oh_z, 32'h00000010);
      if (a == 5) chk("sweep.oh5", oh_z, 32'h00000020);
    end
    for (int a = 0; a < 32; a++) cyc("sweep.rb", 1'b0, 1'b0, 5'd0, '0, 5'(a), 5'(31 - a));
    cyc("sweep.rb5", 1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd0);
    chk("sweep.e5", rd1_z, 32'hA5000005);
    chk("sweep.e0", rd2_z, 32'h0);

    // Zero register vs ordinary entry 0.
    cyc("zr.w", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd1, 5'd2);
    cyc("zr.r", 1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    chk("zr.z", rd1_z, 32'h0);
    chk("zr.n", rd1_n, 32'hFFFFFFFF);

    // Same-cycle read of entry being written.
    cyc("rw9.old", 1'b0, 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
    chk("rw9.same1", rd1_z, 32'h22);
    chk("rw9.same2", rd2_z, 32'h22);
`else
    chk("rw9.same1", rd1_z, 32'h11);
    chk("rw9.same2", rd2_z, 32'h11);
`endif
    pre_chk("rw9");
    edge_chk("rw9");
    chk("rw9.after1", rd1_z, 32'h22);
    chk("rw9.after2", rd2_z, 32'h22);

    // Reset beats a simultaneous write.
    cyc("rp.rst", 1'b1, 1'b1, 5'd3, 32'hDEAD, 5'd3, 5'd4);
    chk("rp.oh", oh_z, 32'h0);
    cyc("rp.rd3", 1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd9);
    chk("rp.e3", rd1_n, 32'h0);
    chk("rp.e9", rd2_z, 32'h0);

    // Dual-port on one entry.
    cyc("dp.w", 1'b0, 1'b1, 5'd15, 32'hCAFEBABE, 5'd1, 5'd1);
    cyc("dp.r", 1'b0, 1'b0, 5'd0, '0, 5'd15, 5'd15);
    chk("dp.r1", rd1_z, 32'hCAFEBABE);
    chk("dp.r2", rd2_z, 32'hCAFEBABE);

    // Random stream against the model.
    for (int n = 0; n < 10000; n++) begin
      logic      r, w;
      reg_addr_t wa, a1, a2;
      r  = ($urandom_range(0, 199) == 0);
      w  = ($urandom_range(0, 9) < 7);
      wa = 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
      cyc("rand", r, w, wa, $urandom, a1, a2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
